pe_row_feeder: RTL and testbench

Input-side feeder for the PE16 systolic array. It accepts one row-vector beat per handshake, each beat carrying ROWS two's-complement 16-bit words. It converts every word to the magnitude-plus-sign form the PE matrix port consumes, in 8-bit or 16-bit packing. It then skews row r by r cycles so the wavefront enters the array diagonally. After the last beat of a frame it drives a fixed-length zero flush so results drain from the array, and it signals completion.

---
 rtl/pe_row_feeder.sv | 164 ++++++++++++++++
 tb/tb_pe_row_feeder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_row_feeder.sv
// Input feeder for the PE16 systolic array: sign/magnitude conversion,
// diagonal row skew and a trailing zero flush with a done pulse.
module pe_row_feeder #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int FLUSH_LEN = ROWS + COLS - 1
) (
  input  logic                 clk,
  input  logic                 _res,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic                 in_width,
  input  logic [ROWS*16-1:0]   in_data,
  output logic [ROWS*16-1:0]   out_mag,
  output logic [ROWS*2-1:0]    out_sign,
  output logic [ROWS-1:0]      out_mode,
  output logic [ROWS-1:0]      out_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(FLUSH_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            mode_q;
  logic            ready_q;
  logic            busy_q;
  logic            done_q;
  logic            accept;

  assign accept   = in_valid & ready_q;
  assign in_ready = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;

  always_ff @(posedge clk) begin
    if (!_res) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            mode_q <= in_width;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (in_last) begin
              state_q <= FLUSH;
              ready_q <= 1'b0;
              done_q  <= (FLUSH_LEN == 1);
            end else begin
              state_q <= STREAM;
            end
          end
        end
        STREAM: begin
          if (accept && in_last) begin
            state_q <= FLUSH;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= (FLUSH_LEN == 1);
          end
        end
        FLUSH: begin
          if (cnt_q == LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else begin
            cnt_q  <= cnt_q + CW'(1);
            done_q <= ((cnt_q + CW'(1)) == LAST);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  function automatic logic [15:0] abs16(input logic [15:0] x);
    return x[15] ? (~x + 16'd1) : x;
  endfunction

  function automatic logic [7:0] abs8(input logic [7:0] x);
    return x[7] ? (~x + 8'd1) : x;
  endfunction

  logic [ROWS*16-1:0] mag_d;
  logic [ROWS*2-1:0]  sign_d;
  logic               mode_d;
  logic               valid_d;
  logic [15:0]        w;

  // first beat of a frame converts with the live width bit
  always_comb begin
    mag_d   = '0;
    sign_d  = '0;
    w       = '0;
    valid_d = accept;
    mode_d  = mode_q;
    if (accept && state_q == IDLE) mode_d = in_width;
    for (int r = 0; r < ROWS; r++) begin
      w = in_data[16*r +: 16];
      if (accept) begin
        if (mode_d) begin
          mag_d[16*r +: 16] = {abs8(w[15:8]), abs8(w[7:0])};
          sign_d[2*r +: 2]  = {w[15], w[7]};
        end else begin
          mag_d[16*r +: 16] = abs16(w);
          sign_d[2*r +: 2]  = {w[15], w[15]};
        end
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [15:0] skew_mag_q  [0:r];
    logic [1:0]  skew_sign_q [0:r];
    logic        skew_mode_q [0:r];
    logic        skew_vld_q  [0:r];

    always_ff @(posedge clk) begin
      if (!_res) begin
        for (int k = 0; k <= r; k++) begin
          skew_mag_q[k]  <= '0;
          skew_sign_q[k] <= '0;
          skew_mode_q[k] <= 1'b0;
          skew_vld_q[k]  <= 1'b0;
        end
      end else begin
        skew_mag_q[0]  <= mag_d[16*r +: 16];
        skew_sign_q[0] <= sign_d[2*r +: 2];
        skew_mode_q[0] <= mode_d;
        skew_vld_q[0]  <= valid_d;
        for (int k = 1; k <= r; k++) begin
          skew_mag_q[k]  <= skew_mag_q[k-1];
          skew_sign_q[k] <= skew_sign_q[k-1];
          skew_mode_q[k] <= skew_mode_q[k-1];
          skew_vld_q[k]  <= skew_vld_q[k-1];
        end
      end
    end

    assign out_mag[16*r +: 16] = skew_mag_q[r];
    assign out_sign[2*r +: 2]  = skew_sign_q[r];
    assign out_mode[r]         = skew_mode_q[r];
    assign out_valid[r]        = skew_vld_q[r];
  end

endmodule

// File: tb/tb_pe_row_feeder.sv
// Bench for pe_row_feeder: table vectors, directed corner sequences
// and random traffic against a cycle-indexed delay-line model.
module tb_pe_row_feeder;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int FL   = ROWS + COLS - 1;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                _res;
  logic                in_valid;
  logic                in_ready;
  logic                in_last;
  logic                in_width;
  logic [ROWS*16-1:0]  in_data;
  logic [ROWS*16-1:0]  out_mag;
  logic [ROWS*2-1:0]   out_sign;
  logic [ROWS-1:0]     out_mode;
  logic [ROWS-1:0]     out_valid;
  logic                busy;
  logic                done;

  pe_row_feeder #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), ._res(_res),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_width(in_width),
    .in_data(in_data),
    .out_mag(out_mag), .out_sign(out_sign),
    .out_mode(out_mode), .out_valid(out_valid),
    .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [ROWS*16-1:0] mag;
    logic [ROWS*2-1:0]  sign;
    logic               mode;
    logic               valid;
  } slot_t;

  slot_t log_q [MAXC];
  int    n        = 0;
  int    last_rst = -1;
  int    phase    = 0;
  int    fcnt     = 0;
  logic  fmode    = 1'b0;
  int    compared = 0;
  int    mism     = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic slot_t conv(input logic [ROWS*16-1:0] d,
                                 input logic m);
    slot_t s;
    s = '0;
    s.valid = 1'b1;
    s.mode  = m;
    for (int r = 0; r < ROWS; r++) begin
      logic [15:0] x;
      int v, h, l;
      x = d[16*r +: 16];
      if (!m) begin
        v = $signed(x);
        if (v < 0) v = -v;
        s.mag[16*r +: 16] = v[15:0];
        s.sign[2*r +: 2]  = {x[15], x[15]};
      end else begin
        h = $signed(x[15:8]);
        l = $signed(x[7:0]);
        if (h < 0) h = -h;
        if (l < 0) l = -l;
        s.mag[16*r +: 16] = {h[7:0], l[7:0]};
        s.sign[2*r +: 2]  = {x[15], x[7]};
      end
    end
    return s;
  endfunction

  task automatic step();
    slot_t s, e;
    logic acc;
    logic [63:0] em;
    logic [7:0]  es;
    logic [3:0]  emo, ev;
    if (n >= MAXC) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", n, MAXC);
      $fatal(1);
    end
    if (_res) begin
      chk("in_ready", in_ready, phase != 2);
      chk("busy", busy, phase != 0);
      chk("done", done, phase == 2 && fcnt == FL - 1);
      acc = in_valid && (phase != 2);
      if (acc) s = conv(in_data, (phase == 0) ? in_width : fmode);
      else begin
        s = '0;
        s.mode = fmode;
      end
      if (phase == 0 && acc) begin
        fmode = in_width;
        phase = in_last ? 2 : 1;
        fcnt  = 0;
      end else if (phase == 1 && acc && in_last) begin
        phase = 2;
        fcnt  = 0;
      end else if (phase == 2) begin
        if (fcnt == FL - 1) begin
          phase = 0;
          fcnt  = 0;
        end else fcnt++;
      end
    end else begin
      s = '0;
      phase = 0;
      fcnt  = 0;
      fmode = 1'b0;
      last_rst = n;
    end
    log_q[n] = s;
    @(posedge clk);
    #1;
    em = '0; es = '0; emo = '0; ev = '0;
    for (int r = 0; r < ROWS; r++) begin
      e = (n - r > last_rst) ? log_q[n-r] : '0;
      em[16*r +: 16] = e.mag[16*r +: 16];
      es[2*r +: 2]   = e.sign[2*r +: 2];
      emo[r]         = e.mode;
      ev[r]          = e.valid;
    end
    chk("out_mag", out_mag, em);
    chk("out_sign", out_sign, es);
    chk("out_mode", out_mode, emo);
    chk("out_valid", out_valid, ev);
    n++;
  endtask

  task automatic idle(input int k);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (k) step();
  endtask

  typedef struct {
    logic        w;
    logic [15:0] x;
    logic [15:0] mag;
    logic [1:0]  sign;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int dn, nd, nr;
    _res = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_width = 1'b0; in_data = '0;
    tbl[0] = '{1'b0, 16'h7FFF, 16'h7FFF, 2'b00};
    tbl[1] = '{1'b0, 16'h8000, 16'h8000, 2'b11};
    tbl[2] = '{1'b0, 16'hFF80, 16'h0080, 2'b11};
    tbl[3] = '{1'b0, 16'h0000, 16'h0000, 2'b00};
    tbl[4] = '{1'b1, 16'hFF80, 16'h0180, 2'b11};
    tbl[5] = '{1'b1, 16'h0581, 16'h057F, 2'b01};
    tbl[6] = '{1'b1, 16'h8080, 16'h8080, 2'b11};
    tbl[7] = '{1'b1, 16'h7F00, 16'h7F00, 2'b00};

    // reset then idle
    repeat (2) step();
    _res = 1'b1;
    chk("rst_mag", out_mag, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_mode", out_mode, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    idle(2);

    // conversion table, one single-beat frame per vector
    foreach (tbl[i]) begin
      in_valid = 1'b1; in_last = 1'b1;
      in_width = tbl[i].w;
      in_data  = {ROWS{tbl[i].x}};
      step();
      chk("tbl_mag", out_mag[15:0], tbl[i].mag);
      chk("tbl_sign", out_sign[1:0], tbl[i].sign);
      chk("tbl_mode", out_mode[0], tbl[i].w);
      chk("tbl_valid", out_valid[0], 1);
      idle(FL + ROWS);
    end

    // distinct words per row, diagonal skew
    in_valid = 1'b1; in_last = 1'b1; in_width = 1'b0;
    in_data  = {16'h0000, 16'hFF80, 16'h8000, 16'h7FFF};
    step();
    in_valid = 1'b0; in_last = 1'b0;
    chk("skew_r0", {out_mag[15:0], out_sign[1:0], out_valid[0]},
        {16'h7FFF, 2'b00, 1'b1});
    step();
    chk("skew_r0_off", out_valid[0], 0);
    chk("skew_r1", {out_mag[31:16], out_sign[3:2], out_valid[1]},
        {16'h8000, 2'b11, 1'b1});
    step();
    chk("skew_r2", {out_mag[47:32], out_sign[5:4], out_valid[2]},
        {16'h0080, 2'b11, 1'b1});
    step();
    chk("skew_r3", {out_mag[63:48], out_sign[7:6], out_valid[3]},
        {16'h0000, 2'b00, 1'b1});
    idle(FL + ROWS);

    // bubble frame and flush length
    in_valid = 1'b1; in_last = 1'b0; in_data = {ROWS{16'h1234}};
    step();
    chk("bub_a", out_valid[0], 1);
    in_valid = 1'b0;
    step();
    chk("bub_gap", out_valid[0], 0);
    in_valid = 1'b1; in_last = 1'b1;
    step();
    chk("bub_b", out_valid[0], 1);
    in_valid = 1'b0; in_last = 1'b0;
    dn = -1; nd = 0; nr = 0;
    for (int k = 1; k <= FL + 2; k++) begin
      if (done) begin dn = k; nd++; end
      if (!in_ready) nr++;
      step();
    end
    chk("done_at", dn, FL);
    chk("done_cnt", nd, 1);
    chk("ready_low", nr, FL);
    idle(ROWS);

    // mode lock, both starting widths
    for (int m = 0; m < 2; m++) begin
      in_data = {ROWS{16'hFF80}};
      for (int b = 0; b < 3; b++) begin
        in_valid = 1'b1;
        in_last  = (b == 2);
        in_width = (b == 0) ? m[0] : ~m[0];
        step();
        chk("lock_mode", out_mode[0], m[0]);
        chk("lock_mag", out_mag[15:0], m[0] ? 16'h0180 : 16'h0080);
      end
      idle(FL + ROWS);
    end

    // reset during flush at count 3
    in_valid = 1'b1; in_last = 1'b1; in_width = 1'b1;
    in_data = {ROWS{16'h8181}};
    step();
    idle(3);
    _res = 1'b0;
    step();
    _res = 1'b1;
    chk("abort_valid", out_valid, 0);
    chk("abort_mag", out_mag, 0);
    chk("abort_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    in_valid = 1'b1; in_last = 1'b0; in_width = 1'b0;
    step();
    chk("abort_accept", out_valid[0], 1);
    chk("abort_mode", out_mode[0], 0);
    nd = 0;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (done) nd++;
      step();
    end
    chk("abort_nodone", nd, 0);
    in_valid = 1'b1; in_last = 1'b1;
    step();
    idle(FL + ROWS);

    // random traffic, source holds beats while stalled
    for (int c = 0; c < 1500; c++) begin
      if (!(in_valid && !in_ready)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_last  = ($urandom_range(0, 4) == 0);
        in_width = $urandom_range(0, 1);
        in_data  = {$urandom, $urandom};
        for (int r = 0; r < ROWS; r++) begin
          case ($urandom_range(0, 9))
            0: in_data[16*r +: 16] = 16'h8000;
            1: in_data[16*r +: 16] = 16'h8080;
            2: in_data[16*r +: 16] = 16'h0080;
            3: in_data[16*r +: 16] = 16'hFFFF;
            default: ;
          endcase
        end
      end
      _res = ($urandom_range(0, 99) != 0);
      step();
    end
    _res = 1'b1;
    idle(FL + ROWS);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mism);
    $finish;
  end

endmodule
